// File: rtl/proc_ctrl_if.sv
// proc_ctrl_if: control/status bundle between the TinyRV1 pipeline control unit and its datapath
interface proc_ctrl_if;
    logic [31:0] d2c_inst;
    logic        d2c_eq_X;
    logic        c2d_imemreq_val_F;
    logic        c2d_reg_en_F;
    logic        c2d_reg_en_D;
    logic [1:0]  c2d_pc_sel_F;
    logic [1:0]  c2d_imm_type_D;
    logic [1:0]  c2d_op1_byp_sel_D;
    logic [1:0]  c2d_op2_byp_sel_D;
    logic        c2d_op1_sel_D;
    logic        c2d_op2_sel_D;
    logic        c2d_alu_fn_X;
    logic        c2d_result_sel_X;
    logic        c2d_dmemreq_val_M;
    logic        c2d_dmemreq_type_M;
    logic        c2d_wb_sel_M;
    logic        c2d_rf_wen_W;
    logic [4:0]  c2d_rf_waddr_W;
    logic        illegal_D;

    modport master (
        input  d2c_inst, d2c_eq_X,
        output c2d_imemreq_val_F, c2d_reg_en_F, c2d_reg_en_D, c2d_pc_sel_F, c2d_imm_type_D,
               c2d_op1_byp_sel_D, c2d_op2_byp_sel_D, c2d_op1_sel_D, c2d_op2_sel_D,
               c2d_alu_fn_X, c2d_result_sel_X, c2d_dmemreq_val_M, c2d_dmemreq_type_M,
               c2d_wb_sel_M, c2d_rf_wen_W, c2d_rf_waddr_W, illegal_D
    );

    modport slave (
        output d2c_inst, d2c_eq_X,
        input  c2d_imemreq_val_F, c2d_reg_en_F, c2d_reg_en_D, c2d_pc_sel_F, c2d_imm_type_D,
               c2d_op1_byp_sel_D, c2d_op2_byp_sel_D, c2d_op1_sel_D, c2d_op2_sel_D,
               c2d_alu_fn_X, c2d_result_sel_X, c2d_dmemreq_val_M, c2d_dmemreq_type_M,
               c2d_wb_sel_M, c2d_rf_wen_W, c2d_rf_waddr_W, illegal_D
    );
endinterface

// File: rtl/proc_ctrl.sv
// proc_ctrl: TinyRV1 five-stage pipeline control (decode, bypass, load-use stall, redirect/squash)
module proc_ctrl (
    input  logic        clk,
    input  logic        rst,
    proc_ctrl_if.master bus
);
    typedef struct packed {
        logic       val;
        logic [4:0] rd;
        logic       wen;
        logic       lw;
        logic       sw;
        logic       bne;
        logic       mul;
    } x_stage_t;

    typedef struct packed {
        logic       val;
        logic [4:0] rd;
        logic       wen;
        logic       lw;
        logic       sw;
    } m_stage_t;

    typedef struct packed {
        logic       val;
        logic [4:0] rd;
        logic       wen;
    } w_stage_t;

    logic     val_D_q, val_D_d;
    x_stage_t x_q, x_d;
    m_stage_t m_q;
    w_stage_t w_q;

    logic [31:0] inst;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic is_add, is_mul, is_addi, is_lw, is_sw, is_jal, is_jr, is_bne;
    logic legal, use1, use2, wen_D;
    logic taken, ld_use, stall, dv, jump;
    logic hx, hm, hw;

    assign inst = bus.d2c_inst;
    assign opc  = inst[6:0];
    assign rd   = inst[11:7];
    assign f3   = inst[14:12];
    assign rs1  = inst[19:15];
    assign rs2  = inst[24:20];
    assign f7   = inst[31:25];

    // First matching producer wins, youngest first; x0 is never forwarded
    function automatic logic [1:0] byp(input logic [4:0] s,
                                       input logic hx_i, input logic [4:0] rx,
                                       input logic hm_i, input logic [4:0] rm,
                                       input logic hw_i, input logic [4:0] rw);
        return (s == 5'd0) ? 2'd0 :
               (hx_i && rx == s) ? 2'd1 :
               (hm_i && rm == s) ? 2'd2 :
               (hw_i && rw == s) ? 2'd3 : 2'd0;
    endfunction

    // Instruction decode of the D-stage instruction
    always_comb begin
        is_add  = opc == 7'b0110011 && f7 == 7'b0000000 && f3 == 3'b000;
        is_mul  = opc == 7'b0110011 && f7 == 7'b0000001 && f3 == 3'b000;
        is_addi = opc == 7'b0010011 && f3 == 3'b000;
        is_lw   = opc == 7'b0000011 && f3 == 3'b010;
        is_sw   = opc == 7'b0100011 && f3 == 3'b010;
        is_jal  = opc == 7'b1101111;
        is_jr   = opc == 7'b1100111 && f3 == 3'b000 && rd == 5'd0 && inst[31:20] == 12'd0;
        is_bne  = opc == 7'b1100011 && f3 == 3'b001;
        legal   = is_add | is_mul | is_addi | is_lw | is_sw | is_jal | is_jr | is_bne;
        use1    = is_add | is_mul | is_addi | is_lw | is_sw | is_jr | is_bne;
        use2    = is_add | is_mul | is_sw | is_bne;
        wen_D   = is_add | is_mul | is_addi | is_lw | is_jal;
    end

    // Hazard resolution: a taken branch in X overrides any D-stage stall or jump
    always_comb begin
        taken  = x_q.val & x_q.bne & ~bus.d2c_eq_X;
        ld_use = val_D_q & x_q.val & x_q.lw & (x_q.rd != 5'd0) &
                 ((use1 & (x_q.rd == rs1)) | (use2 & (x_q.rd == rs2)));
        stall  = ld_use & ~taken;
        dv     = val_D_q & ~taken;
        jump   = dv & ~stall & (is_jal | is_jr);
        hx     = x_q.val & x_q.wen & ~x_q.lw;
        hm     = m_q.val & m_q.wen;
        hw     = w_q.val & w_q.wen;
    end

    // Next state: D holds on a stall, F/D slot is squashed by any redirect
    always_comb begin
        val_D_d = stall ? val_D_q : ~(taken | jump);
        x_d     = '{dv & ~stall, rd, wen_D, is_lw, is_sw, is_bne, is_mul};
    end

    // Pipeline valid bits and per-stage control fields
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            val_D_q <= 1'b0;
            x_q     <= '0;
            m_q     <= '0;
            w_q     <= '0;
        end else begin
            val_D_q <= val_D_d;
            x_q     <= x_d;
            m_q     <= '{x_q.val, x_q.rd, x_q.wen, x_q.lw, x_q.sw};
            w_q     <= '{m_q.val, m_q.rd, m_q.wen};
        end
    end

    // Datapath control outputs; invalid or squashed slots drive zeros
    always_comb begin
        bus.c2d_imemreq_val_F  = rst;
        bus.c2d_reg_en_F       = rst & ~stall;
        bus.c2d_reg_en_D       = rst & ~stall;
        bus.c2d_pc_sel_F       = taken ? 2'd3 : jump ? (is_jal ? 2'd1 : 2'd2) : 2'd0;
        bus.c2d_imm_type_D     = !dv ? 2'd0 : is_sw ? 2'd1 : is_bne ? 2'd2 : is_jal ? 2'd3 : 2'd0;
        bus.c2d_op1_byp_sel_D  = (dv & use1) ? byp(rs1, hx, x_q.rd, hm, m_q.rd, hw, w_q.rd) : 2'd0;
        bus.c2d_op2_byp_sel_D  = (dv & use2) ? byp(rs2, hx, x_q.rd, hm, m_q.rd, hw, w_q.rd) : 2'd0;
        bus.c2d_op1_sel_D      = dv & is_jal;
        bus.c2d_op2_sel_D      = dv & (is_addi | is_lw | is_sw);
        bus.c2d_alu_fn_X       = x_q.val & x_q.bne;
        bus.c2d_result_sel_X   = x_q.val & x_q.mul;
        bus.c2d_dmemreq_val_M  = m_q.val & (m_q.lw | m_q.sw);
        bus.c2d_dmemreq_type_M = m_q.val & m_q.sw;
        bus.c2d_wb_sel_M       = m_q.val & m_q.lw;
        bus.c2d_rf_wen_W       = w_q.val & w_q.wen & (w_q.rd != 5'd0);
        bus.c2d_rf_waddr_W     = w_q.rd;
        bus.illegal_D          = val_D_q & ~legal;
    end
endmodule

// File: tb/tb_proc_ctrl.sv
// tb_proc_ctrl: directed pipeline-control scenarios with a writeback scoreboard
module tb_proc_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    typedef struct { int cyc; logic [4:0] rd; } wb_t;
    wb_t sb[$];

    localparam logic [31:0] nop = 32'h00000013;

    proc_ctrl_if bus ();
    proc_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    logic [24:0] outs;
    assign outs = {bus.c2d_imemreq_val_F, bus.c2d_reg_en_F, bus.c2d_reg_en_D, bus.c2d_pc_sel_F,
                   bus.c2d_imm_type_D, bus.c2d_op1_byp_sel_D, bus.c2d_op2_byp_sel_D,
                   bus.c2d_op1_sel_D, bus.c2d_op2_sel_D, bus.c2d_alu_fn_X, bus.c2d_result_sel_X,
                   bus.c2d_dmemreq_val_M, bus.c2d_dmemreq_type_M, bus.c2d_wb_sel_M,
                   bus.c2d_rf_wen_W, bus.c2d_rf_waddr_W, bus.illegal_D};

    function automatic logic [31:0] f_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] f_mul(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd1, rs2, rs1, 3'd0, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] f_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'd0, rd, 7'b0010011};
    endfunction
    function automatic logic [31:0] f_lw(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, 3'b010, rd, 7'b0000011};
    endfunction
    function automatic logic [31:0] f_sw(input logic [4:0] rs2, input logic [4:0] rs1);
        return {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100011};
    endfunction
    function automatic logic [31:0] f_jal(input logic [4:0] rd);
        return {20'h00800, rd, 7'b1101111};
    endfunction
    function automatic logic [31:0] f_jr(input logic [4:0] rs1);
        return {12'd0, rs1, 3'd0, 5'd0, 7'b1100111};
    endfunction
    function automatic logic [31:0] f_bne(input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'b001, 5'd8, 7'b1100011};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Record an issued writer: its write must appear in W three cycles later
    task automatic exp_wb(input logic [4:0] rd);
        sb.push_back('{cyc + 3, rd});
    endtask

    // One cycle: present D-stage inputs after the edge, then check writeback against the scoreboard
    task automatic step(input logic [31:0] inst, input logic eq);
        @(posedge clk);
        #1;
        bus.d2c_inst = inst;
        bus.d2c_eq_X = eq;
        cyc++;
        #3;
        if (sb.size() != 0 && sb[0].cyc == cyc) begin
            chk($sformatf("c%0d_rf_wen_W", cyc), 32'(bus.c2d_rf_wen_W), 1);
            chk($sformatf("c%0d_rf_waddr_W", cyc), 32'(bus.c2d_rf_waddr_W), 32'(sb[0].rd));
            void'(sb.pop_front());
        end else begin
            chk($sformatf("c%0d_rf_wen_W_idle", cyc), 32'(bus.c2d_rf_wen_W), 0);
        end
    endtask

    initial begin
        bus.d2c_inst = nop;
        bus.d2c_eq_X = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", 32'(outs), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #3;
        chk("c0_imemreq", 32'(bus.c2d_imemreq_val_F), 1);
        chk("c0_reg_en_F", 32'(bus.c2d_reg_en_F), 1);
        chk("c0_reg_en_D", 32'(bus.c2d_reg_en_D), 1);
        // back-to-back ALU dependences
        step(f_addi(5'd1, 5'd0, 12'd5), 1'b0); exp_wb(5'd1);
        chk("c1_op2_sel", 32'(bus.c2d_op2_sel_D), 1);
        chk("c1_op1_byp", 32'(bus.c2d_op1_byp_sel_D), 0);
        step(f_add(5'd2, 5'd1, 5'd1), 1'b0); exp_wb(5'd2);
        chk("c2_op1_byp", 32'(bus.c2d_op1_byp_sel_D), 1);
        chk("c2_op2_byp", 32'(bus.c2d_op2_byp_sel_D), 1);
        chk("c2_op2_sel", 32'(bus.c2d_op2_sel_D), 0);
        step(f_add(5'd3, 5'd2, 5'd1), 1'b0); exp_wb(5'd3);
        chk("c3_op1_byp", 32'(bus.c2d_op1_byp_sel_D), 1);
        chk("c3_op2_byp", 32'(bus.c2d_op2_byp_sel_D), 2);
        step(f_sw(5'd3, 5'd1), 1'b0);
        chk("c4_sw_op1_byp_W", 32'(bus.c2d_op1_byp_sel_D), 3);
        chk("c4_sw_op2_byp_X", 32'(bus.c2d_op2_byp_sel_D), 1);
        chk("c4_sw_imm_type", 32'(bus.c2d_imm_type_D), 1);
        // load-use stall
        step(f_lw(5'd4, 5'd1), 1'b0); exp_wb(5'd4);
        chk("c5_lw_op1_byp", 32'(bus.c2d_op1_byp_sel_D), 0);
        step(f_add(5'd5, 5'd4, 5'd0), 1'b0);
        chk("c6_stall_reg_en_F", 32'(bus.c2d_reg_en_F), 0);
        chk("c6_stall_reg_en_D", 32'(bus.c2d_reg_en_D), 0);
        chk("c6_sw_dmem_val", 32'(bus.c2d_dmemreq_val_M), 1);
        chk("c6_sw_dmem_type", 32'(bus.c2d_dmemreq_type_M), 1);
        step(f_add(5'd5, 5'd4, 5'd0), 1'b0); exp_wb(5'd5);
        chk("c7_reg_en_F", 32'(bus.c2d_reg_en_F), 1);
        chk("c7_op1_byp", 32'(bus.c2d_op1_byp_sel_D), 2);
        chk("c7_wb_sel", 32'(bus.c2d_wb_sel_M), 1);
        chk("c7_dmem_type", 32'(bus.c2d_dmemreq_type_M), 0);
        step(f_mul(5'd7, 5'd5, 5'd4), 1'b0); exp_wb(5'd7);
        chk("c8_bubble_dmem_val", 32'(bus.c2d_dmemreq_val_M), 0);
        chk("c8_op1_byp", 32'(bus.c2d_op1_byp_sel_D), 1);
        chk("c8_op2_byp", 32'(bus.c2d_op2_byp_sel_D), 3);
        step(nop, 1'b0);
        chk("c9_result_sel", 32'(bus.c2d_result_sel_X), 1);
        // taken branch
        step(f_bne(5'd1, 5'd0), 1'b0);
        chk("c10_imm_type", 32'(bus.c2d_imm_type_D), 2);
        chk("c10_op2_sel", 32'(bus.c2d_op2_sel_D), 0);
        step(f_addi(5'd8, 5'd0, 12'd1), 1'b0);
        chk("c11_pc_sel_taken", 32'(bus.c2d_pc_sel_F), 3);
        chk("c11_alu_fn", 32'(bus.c2d_alu_fn_X), 1);
        chk("c11_reg_en_F", 32'(bus.c2d_reg_en_F), 1);
        chk("c11_squash_op2_sel", 32'(bus.c2d_op2_sel_D), 0);
        step(f_sw(5'd1, 5'd1), 1'b0);
        chk("c12_pc_sel", 32'(bus.c2d_pc_sel_F), 0);
        chk("c12_squash_op2_sel", 32'(bus.c2d_op2_sel_D), 0);
        // not-taken branch
        step(f_bne(5'd2, 5'd3), 1'b0);
        chk("c13_pc_sel", 32'(bus.c2d_pc_sel_F), 0);
        chk("c13_dmem_val", 32'(bus.c2d_dmemreq_val_M), 0);
        step(f_addi(5'd9, 5'd2, 12'd1), 1'b1); exp_wb(5'd9);
        chk("c14_not_taken_pc_sel", 32'(bus.c2d_pc_sel_F), 0);
        chk("c14_not_taken_op2_sel", 32'(bus.c2d_op2_sel_D), 1);
        chk("c14_squashed_sw_dmem", 32'(bus.c2d_dmemreq_val_M), 0);
        // jal
        step(f_jal(5'd1), 1'b0); exp_wb(5'd1);
        chk("c15_jal_pc_sel", 32'(bus.c2d_pc_sel_F), 1);
        chk("c15_jal_op1_sel", 32'(bus.c2d_op1_sel_D), 1);
        chk("c15_jal_imm_type", 32'(bus.c2d_imm_type_D), 3);
        step(f_addi(5'd10, 5'd0, 12'd1), 1'b0);
        chk("c16_squash_op2_sel", 32'(bus.c2d_op2_sel_D), 0);
        chk("c16_pc_sel", 32'(bus.c2d_pc_sel_F), 0);
        // jr after load
        step(f_lw(5'd6, 5'd0), 1'b0); exp_wb(5'd6);
        step(f_jr(5'd6), 1'b0);
        chk("c18_jr_stall_reg_en_F", 32'(bus.c2d_reg_en_F), 0);
        chk("c18_jr_stall_pc_sel", 32'(bus.c2d_pc_sel_F), 0);
        step(f_jr(5'd6), 1'b0);
        chk("c19_jr_pc_sel", 32'(bus.c2d_pc_sel_F), 2);
        chk("c19_jr_op1_byp", 32'(bus.c2d_op1_byp_sel_D), 2);
        step(f_jal(5'd5), 1'b0);
        chk("c20_squash_pc_sel", 32'(bus.c2d_pc_sel_F), 0);
        chk("c20_squash_op1_sel", 32'(bus.c2d_op1_sel_D), 0);
        // x0 writes and illegal encoding
        step(f_add(5'd0, 5'd1, 5'd1), 1'b0);
        chk("c21_op1_byp", 32'(bus.c2d_op1_byp_sel_D), 0);
        step(f_add(5'd12, 5'd0, 5'd0), 1'b0); exp_wb(5'd12);
        chk("c22_x0_op1_byp", 32'(bus.c2d_op1_byp_sel_D), 0);
        chk("c22_x0_op2_byp", 32'(bus.c2d_op2_byp_sel_D), 0);
        step(32'hFFFFFFFF, 1'b0);
        chk("c23_illegal", 32'(bus.illegal_D), 1);
        chk("c23_illegal_op2_sel", 32'(bus.c2d_op2_sel_D), 0);
        step(nop, 1'b0);
        chk("c24_illegal_clear", 32'(bus.illegal_D), 0);
        step(nop, 1'b0);
        // mid-run asynchronous reset
        rst = 1'b0;
        #1;
        chk("midrun_reset_outs", 32'(outs), 0);
        @(posedge clk);
        #1;
        bus.d2c_inst = 32'hFFFFFFFF;
        rst = 1'b1;
        #3;
        chk("post_reset_val_D_clear", 32'(bus.illegal_D), 0);
        chk("post_reset_imemreq", 32'(bus.c2d_imemreq_val_F), 1);
        step(32'hFFFFFFFF, 1'b0);
        chk("post_reset_illegal", 32'(bus.illegal_D), 1);
        chk("scoreboard_empty", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
